// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver and key-state tracker.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    localparam int EVT_W        = 10;
    localparam int EVT_CODE_LSB = 0;
    localparam int EVT_EXT_BIT  = 8;
    localparam int EVT_BRK_BIT  = 9;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: pin synchronisers, falling-edge strobe, frame FSM, resync timeout.
// Define PS2_PARITY_CHECK_EN to reject frames whose odd parity fails.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_CHECK = 1'b1;
`else
    localparam bit PAR_CHECK = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_q, fe, din;
    frame_state_t           state, state_nxt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_bit, timeout, stop_ok, stop_bad;
    logic [TW-1:0]          to_cnt;

    // Idle bus is high, so reset the synchronisers to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_q     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_q     <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fe      = clk_q & ~clk_sync[SYNC_STAGES-1];
    assign din     = data_sync[SYNC_STAGES-1];
    assign timeout = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) state_nxt = ST_IDLE;
        else if (fe) begin
            case (state)
                ST_IDLE:   if (!din) state_nxt = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
                ST_PARITY: state_nxt = ST_STOP;
                ST_STOP:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        if (state == ST_STOP && fe && !timeout) begin
            stop_ok  = din && (!PAR_CHECK || (^{shreg, par_bit}));
            stop_bad = !stop_ok;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            frame_err  <= 1'b0;
        end else begin
            if (state == ST_IDLE || fe) to_cnt <= '0;
            else if (!timeout)          to_cnt <= to_cnt + 1'b1;
            if (state == ST_IDLE && fe && !din) bit_cnt <= '0;
            if (state == ST_DATA && fe) begin
                shreg   <= {din, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == ST_PARITY && fe) par_bit <= din;
            byte_valid <= stop_ok;
            frame_err  <= stop_bad | timeout;
            if (stop_ok) rx_byte <= shreg;
        end
    end

endmodule

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard scanner: E0/F0 prefix decode, per-key held bits, FWFT make/break event FIFO.
// Parity enforcement follows the PS2_PARITY_CHECK_EN build option of ps2_frame_rx.
module ps2_key_scanner
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 20000,
    parameter int NUM_KEYS    = 9,
    parameter logic [NUM_KEYS*9-1:0] KEY_CODES = {9'h04B, 9'h042, 9'h03B, 9'h033, 9'h022,
                                                  9'h023, 9'h01B, 9'h01C, 9'h01D},
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] key_down,
    output logic                evt_valid,
    output logic [EVT_W-1:0]    evt_data,
    input  logic                evt_ready,
    output logic                overflow,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic                byte_valid, is_ext, is_brk, push, pop, full, do_push;
    logic [7:0]          rx_byte;
    logic                ext_f, brk_f;
    logic [NUM_KEYS-1:0] hit;
    ps2_evt_t            new_evt;
    ps2_evt_t            mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;

    ps2_frame_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    assign is_ext  = byte_valid && (rx_byte == PS2_PREFIX_EXT);
    assign is_brk  = byte_valid && (rx_byte == PS2_PREFIX_BRK);
    assign push    = byte_valid && !is_ext && !is_brk;
    assign new_evt = '{brk: brk_f, ext: ext_f, code: rx_byte};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (frame_err || push) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else begin
            if (is_ext) ext_f <= 1'b1;
            if (is_brk) brk_f <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        assign hit[i] = push && ({ext_f, rx_byte} == KEY_CODES[9*i +: 9]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) key_down <= '0;
        else     key_down <= (key_down & ~hit) | (hit & {NUM_KEYS{!brk_f}});
    end

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign evt_valid = (wr_ptr != rd_ptr);
    assign full      = ((wr_ptr - rd_ptr) == (AW+1)'(FIFO_DEPTH));
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push && (!full || pop);
    assign evt_data  = evt_valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= new_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            err_cnt  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule
